// File: rtl/attn_csb_pkg.sv
// Shared CSB definitions for the attention-partition host initiator: payload field
// positions, FSM state encoding and request/response pack/unpack helpers.
package attn_csb_pkg;

  localparam int REQ_PD_W    = 63;
  localparam int RSP_PD_W    = 34;
  localparam int ADDR_LSB    = 5;
  localparam int ADDR_W      = 17;
  localparam int WDAT_LSB    = 22;
  localparam int WDAT_W      = 32;
  localparam int WRITE_BIT   = 54;
  localparam int NPOSTED_LSB = 55;
  localparam int RDAT_W      = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } csb_state_e;

  typedef struct packed {
    logic              err;
    logic [RDAT_W-1:0] rdat;
  } csb_rsp_t;

  // Reads always expect a response, so their non-posted flag is forced high.
  function automatic logic [REQ_PD_W-1:0] pack_req(
    input logic [ADDR_W-1:0] addr,
    input logic [WDAT_W-1:0] wdat,
    input logic              write,
    input logic              nposted
  );
    logic [REQ_PD_W-1:0] pd;
    pd                        = '0;
    pd[ADDR_LSB +: ADDR_W]    = addr;
    pd[WDAT_LSB +: WDAT_W]    = wdat;
    pd[WRITE_BIT]             = write;
    pd[NPOSTED_LSB +: 2]      = {1'b0, (write ? nposted : 1'b1)};
    return pd;
  endfunction

  function automatic logic req_is_write(input logic [REQ_PD_W-1:0] pd);
    return pd[WRITE_BIT];
  endfunction

  function automatic logic req_expects_rsp(input logic [REQ_PD_W-1:0] pd);
    return pd[NPOSTED_LSB];
  endfunction

  function automatic csb_rsp_t unpack_rsp(input logic [RSP_PD_W-1:0] pd);
    csb_rsp_t r;
    r.err  = |pd[RSP_PD_W-1:RDAT_W];
    r.rdat = pd[RDAT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/attn_csb_master_if.sv
// Host command/response port and CSB request/response port of attn_csb_master.
// master = the initiator itself, slave = the host + CSB target side (or a bench).
interface attn_csb_master_if;
  import attn_csb_pkg::*;

  // Handshakes: a request transfers on a cycle where valid && ready are both high;
  // valid never drops and the payload never changes until that cycle. The CSB
  // response and the host response carry no ready: each valid cycle is one beat.
  logic                host_cmd_valid;
  logic                host_cmd_ready;
  logic [ADDR_W-1:0]   host_cmd_addr;
  logic [WDAT_W-1:0]   host_cmd_wdat;
  logic                host_cmd_write;
  logic                host_cmd_nposted;

  logic                host_rsp_valid;
  logic [RDAT_W-1:0]   host_rsp_rdat;
  logic                host_rsp_err;
  logic                host_rsp_timeout;
  logic                stray_rsp;

  logic                csb2attn_req_pvld;
  logic                csb2attn_req_prdy;
  logic [REQ_PD_W-1:0] csb2attn_req_pd;

  logic                attn2csb_resp_valid;
  logic [RSP_PD_W-1:0] attn2csb_resp_pd;

  csb_state_e          dbg_state;

  modport master (
    input  host_cmd_valid, host_cmd_addr, host_cmd_wdat, host_cmd_write, host_cmd_nposted,
    output host_cmd_ready,
    output host_rsp_valid, host_rsp_rdat, host_rsp_err, host_rsp_timeout, stray_rsp,
    output csb2attn_req_pvld, csb2attn_req_pd,
    input  csb2attn_req_prdy,
    input  attn2csb_resp_valid, attn2csb_resp_pd,
    output dbg_state
  );

  modport slave (
    output host_cmd_valid, host_cmd_addr, host_cmd_wdat, host_cmd_write, host_cmd_nposted,
    input  host_cmd_ready,
    input  host_rsp_valid, host_rsp_rdat, host_rsp_err, host_rsp_timeout, stray_rsp,
    input  csb2attn_req_pvld, csb2attn_req_pd,
    output csb2attn_req_prdy,
    output attn2csb_resp_valid, attn2csb_resp_pd,
    input  dbg_state
  );

endinterface

// File: rtl/attn_csb_master.sv
// Single-outstanding CSB initiator: latches one host command, issues the CSB request,
// waits (with timeout) for the response when one is due and reports completion.
module attn_csb_master
  import attn_csb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 16
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  attn_csb_master_if.master  bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  csb_state_e          state;
  logic [TO_W-1:0]     to_cnt;
  logic [REQ_PD_W-1:0] req_pd;
  logic                req_pvld;
  logic                cmd_ready;
  logic                rsp_valid;
  logic [RDAT_W-1:0]   rsp_rdat;
  logic                rsp_err;
  logic                rsp_timeout;
  logic                stray;
  csb_rsp_t            rsp_in;

  assign rsp_in = unpack_rsp(bus.attn2csb_resp_pd);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      req_pd      <= '0;
      req_pvld    <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdat    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      stray       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      // Only WAIT_RSP consumes a response; anywhere else it is remembered as stray.
      if (bus.attn2csb_resp_valid && state != WAIT_RSP) begin
        stray <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.host_cmd_valid) begin
            req_pd    <= pack_req(bus.host_cmd_addr, bus.host_cmd_wdat,
                                  bus.host_cmd_write, bus.host_cmd_nposted);
            req_pvld  <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= REQ;
          end
        end

        REQ: begin
          if (bus.csb2attn_req_prdy) begin
            req_pvld <= 1'b0;
            if (req_is_write(req_pd) && !req_expects_rsp(req_pd)) begin
              // Posted write completes on the request handshake itself.
              rsp_valid   <= 1'b1;
              rsp_rdat    <= '0;
              rsp_err     <= 1'b0;
              rsp_timeout <= 1'b0;
              cmd_ready   <= 1'b1;
              state       <= IDLE;
            end else begin
              to_cnt <= '0;
              state  <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          if (bus.attn2csb_resp_valid) begin
            rsp_valid   <= 1'b1;
            rsp_rdat    <= req_is_write(req_pd) ? '0 : rsp_in.rdat;
            rsp_err     <= rsp_in.err;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_rdat    <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          req_pvld  <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.host_cmd_ready    = cmd_ready;
  assign bus.host_rsp_valid    = rsp_valid;
  assign bus.host_rsp_rdat     = rsp_rdat;
  assign bus.host_rsp_err      = rsp_err;
  assign bus.host_rsp_timeout  = rsp_timeout;
  assign bus.stray_rsp         = stray;
  assign bus.csb2attn_req_pvld = req_pvld;
  assign bus.csb2attn_req_pd   = req_pd;
  assign bus.dbg_state         = state;

endmodule

// File: tb/tb_attn_csb_master.sv
// Bench for attn_csb_master: scripted and randomized transactions drive a
// transaction-level expectation model that a per-cycle compare process checks.
module tb_attn_csb_master;
  import attn_csb_pkg::*;

  localparam int T = 8;

  logic clk;
  logic rst;
  attn_csb_master_if bus();

  attn_csb_master #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expectation model ----------------
  logic        m_ready, m_pvld, m_rsp_valid, m_err, m_to, m_stray;
  logic [62:0] m_pd;
  logic [31:0] m_rdat;
  logic [63:0] exp_q[$];
  bit          chk_en;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b1; m_pvld = 1'b0; m_rsp_valid = 1'b0;
    m_err = 1'b0; m_to = 1'b0; m_stray = 1'b0; m_rdat = '0; m_pd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_rsp_valid = 1'b0;
  endtask

  task automatic complete(input logic [31:0] rdat, input logic err, input logic to);
    m_rsp_valid = 1'b1; m_rdat = rdat; m_err = err; m_to = to; m_ready = 1'b1;
  endtask

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", bus.host_cmd_ready, m_ready);
      chk("req_pvld", bus.csb2attn_req_pvld, m_pvld);
      if (m_pvld) chk("req_pd", bus.csb2attn_req_pd, m_pd);
      chk("rsp_valid", bus.host_rsp_valid, m_rsp_valid);
      chk("rsp_rdat", bus.host_rsp_rdat, m_rdat);
      chk("rsp_err", bus.host_rsp_err, m_err);
      chk("rsp_timeout", bus.host_rsp_timeout, m_to);
      chk("stray_rsp", bus.stray_rsp, m_stray);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.host_cmd_valid = 1'b0; bus.host_cmd_addr = '0; bus.host_cmd_wdat = '0;
    bus.host_cmd_write = 1'b0; bus.host_cmd_nposted = 1'b0;
    bus.csb2attn_req_prdy = 1'b0; bus.attn2csb_resp_valid = 1'b0; bus.attn2csb_resp_pd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic stray_pulse();
    bus.attn2csb_resp_valid = 1'b1;
    bus.attn2csb_resp_pd = {2'($urandom_range(0, 3)), 32'($urandom)};
    tick();
    bus.attn2csb_resp_valid = 1'b0;
    m_stray = 1'b1;
  endtask

  task automatic idle_gap(input int n, input bit strays);
    for (int i = 0; i < n; i++) begin
      if (strays && $urandom_range(0, 1) == 1) stray_pulse();
      else tick();
    end
  endtask

  // rsp_dly >= 0: response after that many WAIT_RSP cycles; -1: timeout; -2: reset in WAIT_RSP.
  task automatic do_txn(input logic [16:0] addr, input logic [31:0] wdat, input logic wr,
                        input logic np, input int prdy_dly, input int rsp_dly,
                        input logic [1:0] rsp_st, input logic [31:0] rsp_data,
                        input bit strays, input bit use_lit, input logic [62:0] lit_pd);
    logic np_eff;
    np_eff = wr ? np : 1'b1;
    bus.host_cmd_valid = 1'b1; bus.host_cmd_addr = addr; bus.host_cmd_wdat = wdat;
    bus.host_cmd_write = wr; bus.host_cmd_nposted = np;
    tick();
    bus.host_cmd_valid = 1'b0;
    m_ready = 1'b0; m_pvld = 1'b1;
    m_pd = {6'd0, 1'b0, np_eff, wr, wdat, addr, 5'd0};
    exp_q.push_back({1'b0, m_pd});
    if (use_lit) chk("req_pd_literal", bus.csb2attn_req_pd, lit_pd);
    for (int i = 0; i < prdy_dly; i++) begin
      if (strays && $urandom_range(0, 2) == 0) stray_pulse();
      else tick();
    end
    bus.csb2attn_req_prdy = 1'b1;
    tick();
    bus.csb2attn_req_prdy = 1'b0;
    m_pvld = 1'b0;
    void'(exp_q.pop_front());
    if (wr && !np) begin
      complete('0, 1'b0, 1'b0);
    end else if (rsp_dly >= 0) begin
      repeat (rsp_dly) tick();
      bus.attn2csb_resp_valid = 1'b1;
      bus.attn2csb_resp_pd = {rsp_st, rsp_data};
      tick();
      bus.attn2csb_resp_valid = 1'b0;
      complete(wr ? 32'd0 : rsp_data, |rsp_st, 1'b0);
    end else if (rsp_dly == -1) begin
      repeat (T) tick();
      complete('0, 1'b1, 1'b1);
    end else begin
      repeat (3) tick();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_pvld", bus.csb2attn_req_pvld, 1'b0);
      chk("async_rst_ready", bus.host_cmd_ready, 1'b1);
      chk("async_rst_rsp_valid", bus.host_rsp_valid, 1'b0);
      chk("async_rst_stray", bus.stray_rsp, 1'b0);
      chk("async_rst_state", bus.dbg_state, IDLE);
      tick();
      rst = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_fail = 0; chk_en = 0;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    tick();
    chk_en = 1;
    rst = 1'b0;
    chk("reset_ready", bus.host_cmd_ready, 1'b1);
    chk("reset_pvld", bus.csb2attn_req_pvld, 1'b0);
    chk("reset_pd", bus.csb2attn_req_pd, '0);
    chk("reset_rdat", bus.host_rsp_rdat, '0);
    chk("reset_state", bus.dbg_state, IDLE);
    tick();

    // Read with delayed prdy and response.
    do_txn(17'h00010, 32'h0, 1'b0, 1'b0, 3, 5, 2'b00, 32'hDEADBEEF, 0, 1, 63'h0080_0000_0000_0200);
    chk("read_valid", bus.host_rsp_valid, 1'b1);
    chk("read_rdat", bus.host_rsp_rdat, 32'hDEADBEEF);
    chk("read_err", bus.host_rsp_err, 1'b0);
    idle_gap(2, 0);

    // Timeout, then a late response two cycles after the timeout pulse.
    do_txn(17'h00123, 32'h0, 1'b0, 1'b0, 0, -1, 2'b00, 32'h0, 0, 0, '0);
    chk("timeout_valid", bus.host_rsp_valid, 1'b1);
    chk("timeout_flag", bus.host_rsp_timeout, 1'b1);
    chk("timeout_err", bus.host_rsp_err, 1'b1);
    tick();
    stray_pulse();
    chk("late_rsp_stray", bus.stray_rsp, 1'b1);
    do_reset();

    // Posted write completes on the handshake; a later response is stray.
    do_txn(17'h1FFFF, 32'hA5A5A5A5, 1'b1, 1'b0, 0, 0, 2'b00, 32'h0, 0, 1, 63'h0069_6969_697F_FFE0);
    chk("posted_valid", bus.host_rsp_valid, 1'b1);
    chk("posted_stray_before", bus.stray_rsp, 1'b0);
    tick();
    stray_pulse();
    chk("posted_stray_after", bus.stray_rsp, 1'b1);
    do_reset();

    // Non-posted write with error status.
    do_txn(17'h0ABCD, 32'h5555AAAA, 1'b1, 1'b1, 1, 2, 2'b01, 32'h12345678, 0, 0, '0);
    chk("npw_err", bus.host_rsp_err, 1'b1);
    chk("npw_rdat", bus.host_rsp_rdat, 32'h0);
    chk("npw_timeout", bus.host_rsp_timeout, 1'b0);
    tick();

    // Response on the final timeout cycle wins over the timeout.
    do_txn(17'h00042, 32'h0, 1'b0, 1'b0, 0, T - 1, 2'b00, 32'hCAFEF00D, 0, 0, '0);
    chk("last_cycle_timeout", bus.host_rsp_timeout, 1'b0);
    chk("last_cycle_rdat", bus.host_rsp_rdat, 32'hCAFEF00D);
    tick();
    stray_pulse();

    // Reset inside WAIT_RSP, then a normal read.
    do_txn(17'h00077, 32'h0, 1'b0, 1'b0, 0, -2, 2'b00, 32'h0, 0, 0, '0);
    tick();
    do_txn(17'h00078, 32'h0, 1'b0, 1'b0, 1, 1, 2'b00, 32'h0BADF00D, 0, 0, '0);
    chk("post_reset_rdat", bus.host_rsp_rdat, 32'h0BADF00D);

    // Randomized traffic with stray responses in IDLE and REQ.
    for (int n = 0; n < 60; n++) begin
      logic wr, np;
      int   dly;
      wr  = 1'($urandom_range(0, 1));
      np  = 1'($urandom_range(0, 1));
      dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T - 1));
      do_txn(17'($urandom), $urandom, wr, np, int'($urandom_range(0, 4)), dly,
             2'($urandom_range(0, 3)), $urandom, 1, 0, '0);
      idle_gap(int'($urandom_range(0, 2)), 1);
    end
    tick();
    chk("model_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
